load_store_unit: RTL

//  Responder for the datapath's data-memory requests; sits between the multicycle control/datapath and Memoria64.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side bus of the load/store unit.
// The slave modport is the unit itself; master is the requester plus memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wr
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wr
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store responder: sized little-endian loads with extension, read-modify-write
// for sub-doubleword stores, and rejection of misaligned requests.
module load_store_unit #(
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_RD_LAT);

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic        accept;
    logic        misaligned;

    // Request fields captured at acceptance; the live inputs are ignored afterwards.
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [2:0]  lane_q;
    logic [63:0] wdata_q;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            2'd3:    return |a;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Aligned requests make the byte offset equal to the lane start, so one shift serves all sizes.
    function automatic logic [63:0] load_extend(input logic [63:0] dw, input logic [1:0] size,
                                                input logic [2:0] a, input logic uns);
        logic [63:0] v;
        v = dw >> {a, 3'b000};
        case (size)
            2'd0:    return {{56{~uns & v[7]}},  v[7:0]};
            2'd1:    return {{48{~uns & v[15]}}, v[15:0]};
            2'd2:    return {{32{~uns & v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [63:0] merge_lane(input logic [63:0] old, input logic [63:0] wd,
                                               input logic [1:0] size, input logic [2:0] a);
        logic [63:0] m;
        m = lane_mask(size) << {a, 3'b000};
        return (old & ~m) | ((wd & lane_mask(size)) << {a, 3'b000});
    endfunction

    assign accept        = (state == IDLE) && bus.req_valid;
    assign misaligned    = is_misaligned(bus.req_size, bus.req_addr[2:0]);
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);

    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else if (bus.req_we && (bus.req_size == 2'd3)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            RD: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_next = we_q ? WR : RESP;
                end
            end
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The async reset also clears mem_wr, so an aborted request never completes its write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            size_q        <= '0;
            lane_q        <= '0;
            wdata_q       <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wr    <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.mem_wr <= (state_next == WR);

            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                lane_q  <= bus.req_addr[2:0];
                wdata_q <= bus.req_wdata;
                if (!misaligned) begin
                    bus.mem_addr <= {bus.req_addr[63:3], 3'b000};
                end
            end

            if ((state == IDLE) && (state_next == WR)) begin
                bus.mem_wdata <= bus.req_wdata;
            end else if ((state == RD) && (state_next == WR)) begin
                bus.mem_wdata <= merge_lane(bus.mem_rdata, wdata_q, size_q, lane_q);
            end

            // Response data is loaded only on entry to RESP and holds until the next one.
            if (state_next == RESP) begin
                case (state)
                    IDLE: begin
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b1;
                    end
                    RD: begin
                        bus.rsp_rdata <= load_extend(bus.mem_rdata, size_q, lane_q, uns_q);
                        bus.rsp_err   <= 1'b0;
                    end
                    default: begin
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
